pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter INIT_CYCLES, default 2: number of post-reset cycles during which the pipeline is held.
REQ-002 SHALL have parameter CNT_W, default 16: width of each performance counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports clk_i, rst_i.
REQ-004 SHALL have port clk_i  input  1  rising-edge clock.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port id_rs1_i  input  5  rs1 of the instruction in ID.
REQ-007 SHALL have port id_rs2_i  input  5  rs2 of the instruction in ID.
REQ-008 SHALL have port id_uses_rs2_i  input  1  ID instruction reads rs2 (R-type, sw, beq).
REQ-009 SHALL have port ex_memread_i  input  1  instruction in EX is a load.
REQ-010 SHALL have port ex_rd_i  input  5  destination register of the instruction in EX.
REQ-011 SHALL have port id_branch_taken_i  input  1  branch, jal or jalr resolved taken in ID.
REQ-012 SHALL have port icache_stall_i  input  1  instruction cache busy.
REQ-013 SHALL have port dcache_stall_i  input  1  data cache busy.
REQ-014 SHALL have port pc_write_o  output  1  PC register load enable.
REQ-015 SHALL have port if_id_write_o  output  1  IF/ID register load enable.
REQ-016 SHALL have port noop_o  output  1  drives the Control unit's NoOp input, producing a bubble into ID/EX.
REQ-017 SHALL have port if_flush_o  output  1  clears IF/ID to a no-op.
REQ-018 SHALL have port freeze_o  output  1  holds ID/EX, EX/MEM and MEM/WB.
REQ-019 SHALL have port stall_cycles_o  output  CNT_W  count of cycles with pc_write_o=0 while in RUN or MSTALL.
REQ-020 SHALL have port bubble_cnt_o  output  CNT_W  count of load-use bubbles inserted.
REQ-021 SHALL have port flush_cnt_o  output  CNT_W  count of cycles with if_flush_o=1.

Function
REQ-022 SHALL implement FSM states INIT, RUN and MSTALL, registered on clk_i.
REQ-023 SHALL hold INIT for exactly INIT_CYCLES cycles using a down-counter, then go to RUN regardless of other inputs.
REQ-024 SHALL drive in INIT: pc_write_o=0, if_id_write_o=0, noop_o=1, if_flush_o=0, freeze_o=0.
REQ-025 SHALL define mem_stall = icache_stall_i | dcache_stall_i.
REQ-026 SHALL define load_use = ex_memread_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs1_i) | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
REQ-027 SHALL, in RUN or MSTALL with mem_stall=1 (same cycle, combinational), drive freeze_o=1, pc_write_o=0, if_id_write_o=0, noop_o=0 and if_flush_o=0.
REQ-028 SHALL, in RUN or MSTALL with mem_stall=0 and load_use=1, drive pc_write_o=0, if_id_write_o=0, noop_o=1, if_flush_o=0 and freeze_o=0.
REQ-029 SHALL, in RUN or MSTALL with mem_stall=0, load_use=0 and id_branch_taken_i=1, drive pc_write_o=1, if_id_write_o=1, noop_o=0, if_flush_o=1 and freeze_o=0.
REQ-030 SHALL otherwise drive pc_write_o=1, if_id_write_o=1, noop_o=0, if_flush_o=0 and freeze_o=0.
REQ-031 SHALL apply the priority mem_stall > load_use > branch; a taken branch coinciding with load_use or mem_stall is not flushed, because ID is held and the branch is re-resolved later.
REQ-032 SHALL transition RUN->MSTALL when mem_stall=1 and MSTALL->RUN when mem_stall=0; outputs depend on inputs combinationally, not on state alone.
REQ-033 SHALL keep all outputs free of combinational paths from clk_i; all counters update on the rising edge.
REQ-034 SHALL increment each counter by 1 per qualifying cycle and saturate at all-ones, with no wrap-around.
REQ-035 SHALL have each counter qualify exactly as listed in REQ-019 to REQ-021; INIT cycles do not count.

Reset
REQ-036 SHALL, on rst_i=1 (asynchronous, any cycle, including mid-stall), force state=INIT, INIT counter=INIT_CYCLES and all counters=0.
REQ-037 SHALL, during and immediately after reset, present the INIT output values of REQ-024.
REQ-038 SHALL perform no counting while rst_i=1.

Verification
REQ-039 SHALL verify: release rst_i -> pc_write_o=0 and noop_o=1 for 2 cycles, then pc_write_o=1 in RUN, with all counters at 0.
REQ-040 SHALL verify: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 for one cycle -> noop_o=1, pc_write_o=0, bubble_cnt_o=1; repeat with ex_rd_i=0 -> no bubble.
REQ-041 SHALL verify: dcache_stall_i high for 10 cycles with id_branch_taken_i=1 -> freeze_o=1 and if_flush_o=0 throughout, stall_cycles_o=10; on the next cycle if_flush_o=1 and flush_cnt_o=1.
REQ-042 SHALL verify: load_use and id_branch_taken_i asserted together -> noop_o=1, if_flush_o=0.
REQ-043 SHALL verify: with CNT_W=4, 20 load-use cycles -> bubble_cnt_o saturates at 15.
REQ-044 SHALL verify: rst_i pulsed mid-MSTALL -> immediate INIT outputs and counters=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : 5-stage pipeline hazard controller (init hold, load-use bubble,
//            branch flush, memory-stall freeze) with saturating perf counters.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    input  logic             icache_stall_i,
    input  logic             dcache_stall_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             noop_o,
    output logic             if_flush_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int               IW          = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam logic [IW-1:0]    C_INIT_LOAD = IW'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        MSTALL = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_init_cnt, w_init_cnt_nxt;
    logic          w_mem_stall, w_load_use;
    logic          w_running;
    logic          w_cnt_stall, w_cnt_bubble, w_cnt_flush;

    assign w_mem_stall = icache_stall_i | dcache_stall_i;
    assign w_load_use  = ex_memread_i & (ex_rd_i != 5'd0) &
                         ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= INIT;
            r_init_cnt <= C_INIT_LOAD;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        noop_o         = 1'b0;
        if_flush_o     = 1'b0;
        freeze_o       = 1'b0;
        case (r_state)
            INIT: begin
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
                noop_o        = 1'b1;
                // Leave on the last counted cycle so INIT lasts exactly INIT_CYCLES edges.
                if (r_init_cnt <= IW'(1)) begin
                    w_state_nxt    = RUN;
                    w_init_cnt_nxt = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt - 1'b1;
                end
            end
            RUN, MSTALL: begin
                w_state_nxt = w_mem_stall ? MSTALL : RUN;
                if (w_mem_stall) begin
                    freeze_o      = 1'b1;
                    pc_write_o    = 1'b0;
                    if_id_write_o = 1'b0;
                end else if (w_load_use) begin
                    pc_write_o    = 1'b0;
                    if_id_write_o = 1'b0;
                    noop_o        = 1'b1;
                end else if (id_branch_taken_i) begin
                    if_flush_o = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = INIT;
                w_init_cnt_nxt = C_INIT_LOAD;
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                noop_o         = 1'b1;
            end
        endcase
    end

    assign w_running    = (r_state == RUN) || (r_state == MSTALL);
    assign w_cnt_stall  = w_running & ~pc_write_o;
    assign w_cnt_bubble = w_running & noop_o;
    assign w_cnt_flush  = w_running & if_flush_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            bubble_cnt_o   <= '0;
            flush_cnt_o    <= '0;
        end else begin
            if (w_cnt_stall && (stall_cycles_o != C_CNT_MAX))
                stall_cycles_o <= stall_cycles_o + 1'b1;
            if (w_cnt_bubble && (bubble_cnt_o != C_CNT_MAX))
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            if (w_cnt_flush && (flush_cnt_o != C_CNT_MAX))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed + randomized check of pipeline_hazard_ctrl against a
//            rule-level reference model (two instances: CNT_W=16 and CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int C_INIT = 2;
    localparam int C_WB   = 16;
    localparam int C_WS   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs2 = 1'b0, ex_memread = 1'b0, id_branch_taken = 1'b0;
    logic       icache_stall = 1'b0, dcache_stall = 1'b0;

    logic            pc_write, if_id_write, noop, if_flush, freeze;
    logic [C_WB-1:0] stall_cycles, bubble_cnt, flush_cnt;
    logic            s_pc_write, s_if_id_write, s_noop, s_if_flush, s_freeze;
    logic [C_WS-1:0] s_stall_cycles, s_bubble_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles of init left, and unbounded event counts.
    int     init_left;
    longint n_stall, n_bubble, n_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.INIT_CYCLES(C_INIT), .CNT_W(C_WB)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .id_branch_taken_i(id_branch_taken),
        .icache_stall_i(icache_stall), .dcache_stall_i(dcache_stall),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write), .noop_o(noop),
        .if_flush_o(if_flush), .freeze_o(freeze),
        .stall_cycles_o(stall_cycles), .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
    );

    pipeline_hazard_ctrl #(.INIT_CYCLES(C_INIT), .CNT_W(C_WS)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs2_i(id_uses_rs2),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .id_branch_taken_i(id_branch_taken),
        .icache_stall_i(icache_stall), .dcache_stall_i(dcache_stall),
        .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write), .noop_o(s_noop),
        .if_flush_o(s_if_flush), .freeze_o(s_freeze),
        .stall_cycles_o(s_stall_cycles), .bubble_cnt_o(s_bubble_cnt), .flush_cnt_o(s_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? 32'(m) : 32'(v);
    endfunction

    // Expected control word {pc_write, if_id_write, noop, if_flush, freeze}.
    function automatic logic [4:0] model_ctl();
        bit mem, lu;
        mem = icache_stall | dcache_stall;
        lu  = ex_memread && (ex_rd != 0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        if (rst || init_left > 0) return 5'b00100;
        if (mem)                  return 5'b00001;
        if (lu)                   return 5'b00100;
        if (id_branch_taken)      return 5'b11010;
        return 5'b11000;
    endfunction

    task automatic model_reset();
        init_left = C_INIT;
        n_stall   = 0;
        n_bubble  = 0;
        n_flush   = 0;
    endtask

    task automatic model_tick();
        logic [4:0] c;
        c = model_ctl();
        if (rst) model_reset();
        else if (init_left > 0) init_left--;
        else begin
            if (!c[4]) n_stall++;
            if (c[2])  n_bubble++;
            if (c[1])  n_flush++;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ":ctl"},   {27'd0, pc_write, if_id_write, noop, if_flush, freeze}, {27'd0, model_ctl()});
        check_eq({tag, ":ctl_s"}, {27'd0, s_pc_write, s_if_id_write, s_noop, s_if_flush, s_freeze}, {27'd0, model_ctl()});
        check_eq({tag, ":stall"},   32'(stall_cycles),   sat(n_stall, C_WB));
        check_eq({tag, ":bubble"},  32'(bubble_cnt),     sat(n_bubble, C_WB));
        check_eq({tag, ":flush"},   32'(flush_cnt),      sat(n_flush, C_WB));
        check_eq({tag, ":stall_s"}, 32'(s_stall_cycles), sat(n_stall, C_WS));
        check_eq({tag, ":bubble_s"},32'(s_bubble_cnt),   sat(n_bubble, C_WS));
        check_eq({tag, ":flush_s"}, 32'(s_flush_cnt),    sat(n_flush, C_WS));
    endtask

    // Inputs are driven at posedge+1; outputs are checked at the falling edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; id_branch_taken = 1'b0;
        icache_stall = 1'b0; dcache_stall = 1'b0;
    endtask

    // Reset asserted between clock edges; effect must be visible before any edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all({tag, ":async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        cycle({tag, ":init0"});
        cycle({tag, ":init1"});
    endtask

    task automatic load_use_on(input logic [4:0] rd);
        ex_memread = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_rs2 = 5'd9; id_uses_rs2 = 1'b0;
    endtask

    initial begin
        model_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk); model_tick(); #1;
        cycle("rst_hold");
        rst = 1'b0;
        cycle("init0");
        cycle("init1");
        check_eq("run_pc_write", 32'(pc_write), 32'd1);
        check_eq("run_stall0",   32'(stall_cycles), 32'd0);

        // Load-use with rd=5 then rd=0.
        load_use_on(5'd5);
        #1;
        check_eq("lu_noop", 32'(noop), 32'd1);
        check_eq("lu_pc",   32'(pc_write), 32'd0);
        cycle("lu");
        check_eq("lu_bubble1", 32'(bubble_cnt), 32'd1);
        load_use_on(5'd0);
        id_rs1 = 5'd0;
        #1;
        check_eq("lu_x0_noop", 32'(noop), 32'd0);
        cycle("lu_x0");
        check_eq("lu_x0_bubble", 32'(bubble_cnt), 32'd1);
        set_idle();

        // Load-use dominates a taken branch.
        load_use_on(5'd5);
        id_branch_taken = 1'b1;
        #1;
        check_eq("lu_br_noop",  32'(noop), 32'd1);
        check_eq("lu_br_flush", 32'(if_flush), 32'd0);
        cycle("lu_br");
        set_idle();

        // Data-cache stall with a pending taken branch, from a clean reset.
        async_reset("pre_dc");
        dcache_stall = 1'b1; id_branch_taken = 1'b1;
        for (int i = 0; i < 10; i++) cycle("dc_stall");
        check_eq("dc_stall10", 32'(stall_cycles), 32'd10);
        dcache_stall = 1'b0;
        #1;
        check_eq("dc_flush_now", 32'(if_flush), 32'd1);
        cycle("dc_flush");
        check_eq("dc_flush_cnt", 32'(flush_cnt), 32'd1);
        set_idle();

        // Bubble counter saturation on the narrow instance.
        load_use_on(5'd5);
        for (int i = 0; i < 20; i++) cycle("sat");
        check_eq("sat_bubble_s", 32'(s_bubble_cnt), 32'd15);
        set_idle();

        // Reset in the middle of a memory stall.
        icache_stall = 1'b1;
        repeat (3) cycle("mstall");
        async_reset("mid_mstall");

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            id_rs1          = 5'($urandom_range(0, 7));
            id_rs2          = 5'($urandom_range(0, 7));
            ex_rd           = 5'($urandom_range(0, 7));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_memread      = 1'($urandom_range(0, 1));
            id_branch_taken = ($urandom_range(0, 9) < 3);
            icache_stall    = ($urandom_range(0, 9) == 0);
            dcache_stall    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
